instr_feeder: RTL

INSTR_FEEDER -- requirements
Module: instr_feeder

---
 rtl/instr_feeder_pkg.sv | 52 +++++
 rtl/instr_feeder_prog_ram.sv | 22 ++
 rtl/instr_feeder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/instr_feeder_pkg.sv
// Shared constants, FSM state type and instruction field decode for instr_feeder.
package instr_feeder_pkg;

  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_SUB  = 6'd1;
  localparam logic [5:0] OP_AND  = 6'd2;
  localparam logic [5:0] OP_OR   = 6'd3;
  localparam logic [5:0] OP_XOR  = 6'd4;
  localparam logic [5:0] OP_SLT  = 6'd5;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_SUBI = 6'd9;
  localparam logic [5:0] OP_SLTI = 6'd10;
  localparam logic [5:0] OP_LW   = 6'd11;
  localparam logic [5:0] OP_HLT  = 6'h3F;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] HLT_WORD = 32'hFC00_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_READY,
    ST_RUN,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic       wr;
    logic [4:0] dst;
    logic [4:0] rs;
    logic [4:0] rt;
  } fields_t;

  // RR ops write rd [15:11]; immediate/load ops write rt [20:16].
  function automatic fields_t f_decode(input logic [31:0] w);
    fields_t f;
    f.rs  = w[25:21];
    f.rt  = w[20:16];
    f.wr  = 1'b0;
    f.dst = '0;
    if (w[31:26] <= OP_SLT) begin
      f.wr  = 1'b1;
      f.dst = w[15:11];
    end else if (w[31:26] == OP_ADDI || w[31:26] == OP_SUBI ||
                 w[31:26] == OP_SLTI || w[31:26] == OP_LW) begin
      f.wr  = 1'b1;
      f.dst = w[20:16];
    end
    return f;
  endfunction

endpackage

// File: rtl/instr_feeder_prog_ram.sv
// Program store: one synchronous write port, one asynchronous read port, no reset.
module feeder_prog_ram #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk1,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [31:0]       i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk1) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_feeder.sv
// Loads a program from the host, then streams it one word per cycle to the core.
// Optional RAW bubble insertion is enabled by defining INSTR_FEEDER_HAZARD_NOP_EN.
module instr_feeder
  import instr_feeder_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  input  logic              start,
  output logic [31:0]       instr_out,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] LAST_ADR = (ADDR_W+1)'(DEPTH-1);

  state_t            r_state;
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic [ADDR_W:0]   r_prog_len;
  logic              w_accept;
  logic [ADDR_W-1:0] w_waddr;
  logic [31:0]       w_rdata;
  logic              w_at_end;
  logic              w_stall;

  assign load_ready = (r_state == ST_IDLE) || (r_state == ST_LOAD) || (r_state == ST_DONE);
  assign busy       = (r_state == ST_LOAD) || (r_state == ST_RUN);
  assign done       = (r_state == ST_DONE);
  assign w_accept   = load_valid && load_ready;
  assign w_waddr    = (r_state == ST_LOAD) ? r_wr_ptr[ADDR_W-1:0] : '0;
  assign w_at_end   = (r_rd_ptr == r_prog_len);

  feeder_prog_ram #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk1   (clk1),
    .i_we   (w_accept),
    .i_waddr(w_waddr),
    .i_wdata(load_data),
    .i_raddr(r_rd_ptr[ADDR_W-1:0]),
    .o_rdata(w_rdata)
  );

`ifdef INSTR_FEEDER_HAZARD_NOP_EN
  fields_t    w_cur;
  logic [4:0] r_hz_dst;
  logic [1:0] r_hz_age;

  // Age counts issue slots since the last producer; consumer may issue at age 3.
  assign w_cur   = f_decode(w_rdata);
  assign w_stall = !w_at_end && (r_hz_dst != 5'd0) && (r_hz_age != 2'd3) &&
                   ((w_cur.rs == r_hz_dst) || (w_cur.rt == r_hz_dst));

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      r_hz_dst <= '0;
      r_hz_age <= '0;
    end else if (r_state == ST_READY && start) begin
      r_hz_dst <= '0;
      r_hz_age <= '0;
    end else if (r_state == ST_RUN && !w_at_end) begin
      if (!w_stall && w_cur.wr) begin
        r_hz_dst <= w_cur.dst;
        r_hz_age <= 2'd1;
      end else if (r_hz_age != 2'd3) begin
        r_hz_age <= r_hz_age + 2'd1;
      end
    end
  end
`else
  assign w_stall = 1'b0;
`endif

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_prog_len  <= '0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      pc_out      <= '0;
    end else begin
      instr_out   <= NOP_WORD;
      instr_valid <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_wr_ptr <= ONE;
            if (load_last) begin
              r_prog_len <= ONE;
              r_state    <= ST_READY;
            end else begin
              r_state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + ONE;
            if (load_last || r_wr_ptr == LAST_ADR) begin
              r_prog_len <= r_wr_ptr + ONE;
              r_state    <= ST_READY;
            end
          end
        end
        ST_READY: begin
          if (start) begin
            r_rd_ptr <= '0;
            r_state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_at_end) begin
            instr_out   <= HLT_WORD;
            instr_valid <= 1'b1;
            pc_out      <= r_rd_ptr[ADDR_W-1:0];
            r_state     <= ST_DONE;
          end else if (!w_stall) begin
            instr_out   <= w_rdata;
            instr_valid <= 1'b1;
            pc_out      <= r_rd_ptr[ADDR_W-1:0];
            r_rd_ptr    <= r_rd_ptr + ONE;
            if (w_rdata[31:26] == OP_HLT) r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
